// File: rtl/dmem_wbuf.sv
// dmem_wbuf: word RAM fronted by a store FIFO. Core stores enqueue
// unconditionally; a loader port and the FIFO drain share the single
// RAM write port under a two-state priority FSM. Reads are combinational
// and forward the youngest pending store to the same word.
// Optional build macro: DMEM_WBUF_STATS_EN adds ld_stall_cnt and wb_peak.
module dmem_wbuf #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4,
  parameter int LOW_WM = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  output logic [31:0]              ReadData,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [31:0]              ld_data,
  output logic [$clog2(DEPTH):0]   wb_count
`ifdef DMEM_WBUF_STATS_EN
  ,
  output logic [31:0]              ld_stall_cnt,
  output logic [$clog2(DEPTH):0]   wb_peak
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] HI_LVL = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LO_LVL = CNT_W'(LOW_WM);

  typedef enum logic {LOAD_PRI, DRAIN_PRI} state_t;

  // Storage
  logic [31:0]       r_ram       [2**ADDR_W];
  logic [ADDR_W-1:0] r_fifo_idx  [DEPTH];
  logic [31:0]       r_fifo_data [DEPTH];

  // Control state
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W-1:0] w_idx;
  logic              w_ld_fire;
  logic              w_drain;
  logic              w_fwd_hit;
  logic [31:0]       w_fwd_data;
  logic [PTR_W-1:0]  w_slot;
  logic              w_addr_unused;

  // Byte-offset and out-of-range address bits do not select a word.
  assign w_addr_unused = &{1'b0, DataAdr[31:ADDR_W+2], DataAdr[1:0]};
  assign w_idx         = DataAdr[ADDR_W+1:2];

  // Loader only gets the port in LOAD_PRI and while the FIFO has headroom;
  // otherwise the head drains whenever something is pending.
  assign ld_ready  = (r_state == LOAD_PRI) && (r_count < HI_LVL);
  assign w_ld_fire = ld_valid && ld_ready;
  assign w_drain   = !w_ld_fire && (r_count != '0);
  assign wb_count  = r_count;

  // FIFO pointers, occupancy and FSM state register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= LOAD_PRI;
    end else begin
      if (MemWrite) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_drain)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({MemWrite, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_state <= w_state_next;
    end
  end

  // Next-state logic: switch to drain priority near full, back once low.
  // NOTE: assigning a default first keeps this combinational block from inferring a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD_PRI:  if (r_count >= HI_LVL) w_state_next = DRAIN_PRI;
      DRAIN_PRI: if (r_count <= LO_LVL) w_state_next = LOAD_PRI;
      default:   w_state_next = LOAD_PRI;
    endcase
  end

  // FIFO payload and RAM write port; loader beats a drain in the same cycle.
  // NOTE: array storage has no reset; only the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (MemWrite) begin
      r_fifo_idx[r_wr_ptr]  <= w_idx;
      r_fifo_data[r_wr_ptr] <= WriteData;
    end
    if (w_ld_fire) begin
      r_ram[ld_addr] <= ld_data;
    end else if (w_drain) begin
      r_ram[r_fifo_idx[r_rd_ptr]] <= r_fifo_data[r_rd_ptr];
    end
  end

  // Read path: scan live entries oldest to youngest so the youngest match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_slot     = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot = r_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_fifo_idx[w_slot] == w_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_fifo_data[w_slot];
      end
    end
    ReadData = w_fwd_hit ? w_fwd_data : r_ram[w_idx];
  end

`ifdef DMEM_WBUF_STATS_EN
  logic [31:0]      r_stall_cnt;
  logic [CNT_W-1:0] r_peak;

  // Saturating loader-stall counter and occupancy high-water mark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_peak      <= '0;
    end else begin
      if (ld_valid && !ld_ready && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (r_count > r_peak)
        r_peak <= r_count;
    end
  end

  assign ld_stall_cnt = r_stall_cnt;
  assign wb_peak      = r_peak;
`endif

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf (default parameters). Stats outputs are
// checked only when DMEM_WBUF_STATS_EN is defined.
module tb_dmem_wbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic [2:0]  wb_count;
`ifdef DMEM_WBUF_STATS_EN
  logic [31:0] ld_stall_cnt;
  logic [2:0]  wb_peak;
`endif

  int checks   = 0;
  int failures = 0;

  dmem_wbuf #(.ADDR_W(8), .DEPTH(4), .LOW_WM(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .wb_count  (wb_count)
`ifdef DMEM_WBUF_STATS_EN
    ,
    .ld_stall_cnt (ld_stall_cnt),
    .wb_peak      (wb_peak)
`endif
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Idle until the FIFO is empty, giving up after a bounded number of cycles.
  task automatic wait_empty(output bit ok);
    ok = 1'b0;
    MemWrite = 1'b0;
    ld_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (wb_count == 3'd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (wb_count !== 3'd0) begin
      failures++; $display("FAIL reset_count: got %0d expected 0", wb_count);
    end
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b expected 1", ld_ready);
    end
  endtask

  task automatic test_store_forward();
    // Seed word 4 through the loader so the pre-store value is known.
    ld_valid = 1'b1; ld_addr = 8'd4; ld_data = 32'hDEAD_0004;
    tick();
    ld_valid  = 1'b0;
    MemWrite  = 1'b1; DataAdr = 32'h10; WriteData = 32'h1234_5678;
    #1;
    checks++;
    if (ReadData !== 32'hDEAD_0004) begin
      failures++; $display("FAIL own_cycle_no_fwd: got %h expected dead0004", ReadData);
    end
    tick();
    MemWrite = 1'b0;
    #1;
    checks++;
    if (ReadData !== 32'h1234_5678) begin
      failures++; $display("FAIL fwd_next: got %h expected 12345678", ReadData);
    end
    checks++;
    if (wb_count !== 3'd1) begin
      failures++; $display("FAIL fwd_count: got %0d expected 1", wb_count);
    end
    tick();
    #1;
    checks++;
    if (wb_count !== 3'd0) begin
      failures++; $display("FAIL drain_count: got %0d expected 0", wb_count);
    end
    checks++;
    if (ReadData !== 32'h1234_5678) begin
      failures++; $display("FAIL ram_commit: got %h expected 12345678", ReadData);
    end
    DataAdr = 32'h8000_0013;
    #1;
    checks++;
    if (ReadData !== 32'h1234_5678) begin
      failures++; $display("FAIL addr_ignored_bits: got %h expected 12345678", ReadData);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ld_valid = 1'b1; ld_addr = 8'h30; ld_data = 32'h0000_CAFE;
    MemWrite = 1'b1; DataAdr = 32'h20; WriteData = 32'hA;
    tick();
    WriteData = 32'hB;
    #1;
    checks++;
    if (ReadData !== 32'hA) begin
      failures++; $display("FAIL b2b_first: got %h expected a", ReadData);
    end
    tick();
    MemWrite = 1'b0;
    #1;
    checks++;
    if (ReadData !== 32'hB) begin
      failures++; $display("FAIL b2b_youngest: got %h expected b", ReadData);
    end
    checks++;
    if (wb_count !== 3'd2) begin
      failures++; $display("FAIL b2b_count: got %0d expected 2", wb_count);
    end
    wait_empty(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL b2b_drain_timeout: got count %0d expected 0", wb_count);
    end
    checks++;
    if (ReadData !== 32'hB) begin
      failures++; $display("FAIL b2b_ram: got %h expected b", ReadData);
    end
    DataAdr = 32'hC0;
    #1;
    checks++;
    if (ReadData !== 32'h0000_CAFE) begin
      failures++; $display("FAIL b2b_loader_word: got %h expected cafe", ReadData);
    end
  endtask

  task automatic test_drain_priority();
    bit ok;
    int exp_cnt [10] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0};
    bit exp_rdy [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    ld_valid = 1'b1; ld_addr = 8'h50; ld_data = 32'h5050;
    for (int c = 0; c < 10; c++) begin
      MemWrite  = (c < 6);
      DataAdr   = 32'(32'h100 + c * 4);
      WriteData = 32'(32'h3000 + c);
      #1;
      checks++;
      if (wb_count !== 3'(exp_cnt[c])) begin
        failures++; $display("FAIL drain_count[%0d]: got %0d expected %0d", c, wb_count, exp_cnt[c]);
      end
      checks++;
      if (ld_ready !== exp_rdy[c]) begin
        failures++; $display("FAIL drain_ready[%0d]: got %b expected %b", c, ld_ready, exp_rdy[c]);
      end
      tick();
    end
    ld_valid = 1'b0;
    MemWrite = 1'b0;
`ifdef DMEM_WBUF_STATS_EN
    #1;
    checks++;
    if (ld_stall_cnt !== 32'd6) begin
      failures++; $display("FAIL stats_stall: got %0d expected 6", ld_stall_cnt);
    end
    checks++;
    if (wb_peak !== 3'd3) begin
      failures++; $display("FAIL stats_peak: got %0d expected 3", wb_peak);
    end
`endif
    wait_empty(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL drain_timeout: got count %0d expected 0", wb_count);
    end
    DataAdr = 32'h100;
    #1;
    checks++;
    if (ReadData !== 32'h3000) begin
      failures++; $display("FAIL drain_ram_first: got %h expected 3000", ReadData);
    end
    DataAdr = 32'h114;
    #1;
    checks++;
    if (ReadData !== 32'h3005) begin
      failures++; $display("FAIL drain_ram_last: got %h expected 3005", ReadData);
    end
  endtask

  task automatic test_loader_order();
    MemWrite = 1'b1; DataAdr = 32'h14; WriteData = 32'h77;
    ld_valid = 1'b1; ld_addr = 8'd5; ld_data = 32'h55;
    tick();
    MemWrite = 1'b0;
    #1;
    checks++;
    if (ReadData !== 32'h77) begin
      failures++; $display("FAIL order_pending: got %h expected 77", ReadData);
    end
    tick();
    ld_valid = 1'b0;
    #1;
    checks++;
    if (ReadData !== 32'h77) begin
      failures++; $display("FAIL order_over_loader: got %h expected 77", ReadData);
    end
    tick();
    #1;
    checks++;
    if (wb_count !== 3'd0) begin
      failures++; $display("FAIL order_count: got %0d expected 0", wb_count);
    end
    checks++;
    if (ReadData !== 32'h77) begin
      failures++; $display("FAIL order_final: got %h expected 77", ReadData);
    end
  endtask

  task automatic test_reset_discard();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_addr = 8'(8'h60 + i); ld_data = 32'(32'h600 + i);
      tick();
    end
    ld_addr = 8'h70; ld_data = 32'h700;
    for (int i = 0; i < 3; i++) begin
      MemWrite = 1'b1; DataAdr = 32'((32'h60 + i) * 4); WriteData = 32'(32'hBAD0 + i);
      tick();
    end
    MemWrite = 1'b0;
    ld_valid = 1'b0;
    #1;
    checks++;
    if (wb_count !== 3'd3) begin
      failures++; $display("FAIL discard_pre_count: got %0d expected 3", wb_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (wb_count !== 3'd0) begin
      failures++; $display("FAIL discard_async_count: got %0d expected 0", wb_count);
    end
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++; $display("FAIL discard_async_ready: got %b expected 1", ld_ready);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      DataAdr = 32'((32'h60 + i) * 4);
      #1;
      checks++;
      if (ReadData !== 32'(32'h600 + i)) begin
        failures++; $display("FAIL discard_word[%0d]: got %h expected %h", i, ReadData, 32'h600 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_forward();
    test_back_to_back();
    test_drain_priority();
    test_loader_order();
    test_reset_discard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
